// File: rtl/axi_burst_master.sv
// axi_burst_master
//   AXI4 initiator that converts a single core-side request (address, length,
//   read/write) into one INCR burst on the AXI bus, streams beats to/from the
//   client through valid/ready handshakes, and pulses done with the final
//   response before returning to idle. Only one transaction is in flight.
//
// Ports
//   ACLK, ARESET        clock (rising edge), synchronous active-high reset
//   req_*               client request channel (valid/ready, write flag,
//                       word-aligned start address, length = beats-1)
//   wr_*                client write-beat stream into the master
//   rd_*                client read-beat stream out of the master
//   done, resp          one-cycle end-of-transaction pulse, response code
//   AR*/R*/AW*/W*/B*_M  AXI4 master channels
module axi_burst_master #(
    parameter int ID_W      = 4,
    parameter int MASTER_ID = 0,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    // client request
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [LEN_W-1:0]    req_len,
    // client write beats
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic                wr_valid,
    output logic                wr_ready,
    // client read beats
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                rd_valid,
    input  logic                rd_ready,
    // completion
    output logic                done,
    output logic [1:0]          resp,
    // AXI read address
    output logic [ID_W-1:0]     ARID_M,
    output logic [ADDR_W-1:0]   ARADDR_M,
    output logic [7:0]          ARLEN_M,
    output logic [2:0]          ARSIZE_M,
    output logic [1:0]          ARBURST_M,
    output logic                ARVALID_M,
    input  logic                ARREADY_M,
    // AXI read data
    input  logic [ID_W-1:0]     RID_M,
    input  logic [DATA_W-1:0]   RDATA_M,
    input  logic [1:0]          RRESP_M,
    input  logic                RLAST_M,
    input  logic                RVALID_M,
    output logic                RREADY_M,
    // AXI write address
    output logic [ID_W-1:0]     AWID_M,
    output logic [ADDR_W-1:0]   AWADDR_M,
    output logic [7:0]          AWLEN_M,
    output logic [2:0]          AWSIZE_M,
    output logic [1:0]          AWBURST_M,
    output logic                AWVALID_M,
    input  logic                AWREADY_M,
    // AXI write data
    output logic [DATA_W-1:0]   WDATA_M,
    output logic [DATA_W/8-1:0] WSTRB_M,
    output logic                WLAST_M,
    output logic                WVALID_M,
    input  logic                WREADY_M,
    // AXI write response
    input  logic [ID_W-1:0]     BID_M,
    input  logic [1:0]          BRESP_M,
    input  logic                BVALID_M,
    output logic                BREADY_M
);

    localparam logic [ID_W-1:0] MID = ID_W'(MASTER_ID);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [LEN_W-1:0]    len_reg, len_next;
    logic [LEN_W-1:0]    cnt_reg, cnt_next;
    logic [1:0]          resp_reg, resp_next;
    logic                done_reg, done_next;
    logic [1:0]          beat_err;
    logic                cnt_at_len;

    assign cnt_at_len = (cnt_reg == len_reg);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            len_reg   <= '0;
            cnt_reg   <= '0;
            resp_reg  <= 2'b00;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            resp_reg  <= resp_next;
            done_reg  <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        resp_next  = resp_reg;
        done_next  = 1'b0;
        beat_err   = 2'b00;

        case (state_reg)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_next  = req_addr;
                    len_next   = req_len;
                    cnt_next   = '0;
                    resp_next  = 2'b00;
                    state_next = req_write ? S_AW : S_AR;
                end
            end

            S_AR: begin
                if (ARREADY_M) begin
                    state_next = S_R;
                end
            end

            S_R: begin
                if (RVALID_M && RREADY_M) begin
                    // A slave error code wins; otherwise a wrong ID or an
                    // RLAST that disagrees with the beat count is SLVERR.
                    if (RRESP_M != 2'b00) begin
                        beat_err = RRESP_M;
                    end else if ((RID_M != MID) || (RLAST_M != cnt_at_len)) begin
                        beat_err = 2'b10;
                    end
                    // Sticky: the first error of the burst is the one reported.
                    if (resp_reg == 2'b00) begin
                        resp_next = beat_err;
                    end
                    // Saturate at len so an overlong burst cannot wrap.
                    if (!cnt_at_len) begin
                        cnt_next = cnt_reg + LEN_W'(1);
                    end
                    if (RLAST_M) begin
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end

            S_AW: begin
                if (AWREADY_M) begin
                    state_next = S_W;
                end
            end

            S_W: begin
                if (wr_valid && WREADY_M) begin
                    if (cnt_at_len) begin
                        state_next = S_B;
                    end else begin
                        cnt_next = cnt_reg + LEN_W'(1);
                    end
                end
            end

            S_B: begin
                if (BVALID_M) begin
                    resp_next  = (BID_M != MID) ? 2'b10 : BRESP_M;
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: state-decoded from registers or direct pass-through
    // ------------------------------------------------------------------
    // Holding req_ready low during the done pulse keeps the two exclusive.
    assign req_ready = (state_reg == S_IDLE) && !done_reg;
    assign done      = done_reg;
    assign resp      = resp_reg;

    assign ARID_M    = MID;
    assign ARADDR_M  = addr_reg;
    assign ARLEN_M   = 8'(len_reg);
    assign ARSIZE_M  = 3'b010;
    assign ARBURST_M = 2'b01;
    assign ARVALID_M = (state_reg == S_AR);

    assign RREADY_M  = (state_reg == S_R) && rd_ready;
    assign rd_valid  = (state_reg == S_R) && RVALID_M;
    assign rd_last   = (state_reg == S_R) && RLAST_M;
    assign rd_data   = RDATA_M;

    assign AWID_M    = MID;
    assign AWADDR_M  = addr_reg;
    assign AWLEN_M   = 8'(len_reg);
    assign AWSIZE_M  = 3'b010;
    assign AWBURST_M = 2'b01;
    assign AWVALID_M = (state_reg == S_AW);

    assign WVALID_M  = (state_reg == S_W) && wr_valid;
    assign wr_ready  = (state_reg == S_W) && WREADY_M;
    assign WLAST_M   = (state_reg == S_W) && cnt_at_len;
    assign WDATA_M   = wr_data;
    assign WSTRB_M   = wr_strb;

    assign BREADY_M  = (state_reg == S_B);

endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master
//   Directed bench for axi_burst_master: a read burst with delayed ARREADY,
//   a two-beat write, read backpressure, error responses, reset in the middle
//   of a write, and a single-beat read. Beats offered by the slave/client
//   model are pushed to a scoreboard queue and popped when the DUT hands them
//   on.
module tb_axi_burst_master;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    logic                ACLK;
    logic                ARESET;
    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [ADDR_W-1:0]   req_addr;
    logic [LEN_W-1:0]    req_len;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_strb;
    logic                wr_valid;
    logic                wr_ready;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_last;
    logic                rd_valid;
    logic                rd_ready;
    logic                done;
    logic [1:0]          resp;
    logic [ID_W-1:0]     ARID_M;
    logic [ADDR_W-1:0]   ARADDR_M;
    logic [7:0]          ARLEN_M;
    logic [2:0]          ARSIZE_M;
    logic [1:0]          ARBURST_M;
    logic                ARVALID_M;
    logic                ARREADY_M;
    logic [ID_W-1:0]     RID_M;
    logic [DATA_W-1:0]   RDATA_M;
    logic [1:0]          RRESP_M;
    logic                RLAST_M;
    logic                RVALID_M;
    logic                RREADY_M;
    logic [ID_W-1:0]     AWID_M;
    logic [ADDR_W-1:0]   AWADDR_M;
    logic [7:0]          AWLEN_M;
    logic [2:0]          AWSIZE_M;
    logic [1:0]          AWBURST_M;
    logic                AWVALID_M;
    logic                AWREADY_M;
    logic [DATA_W-1:0]   WDATA_M;
    logic [DATA_W/8-1:0] WSTRB_M;
    logic                WLAST_M;
    logic                WVALID_M;
    logic                WREADY_M;
    logic [ID_W-1:0]     BID_M;
    logic [1:0]          BRESP_M;
    logic                BVALID_M;
    logic                BREADY_M;

    int vec_cnt = 0;
    int err_cnt = 0;

    // scoreboard entry: [31:0] data, [35:32] strobe, [36] last
    logic [40:0] sb[$];

    axi_burst_master #(
        .ID_W(ID_W), .MASTER_ID(0), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .resp(resp),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
        .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
        .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
        .WREADY_M(WREADY_M),
        .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic issue_req(input logic wr, input logic [31:0] addr, input logic [3:0] len);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_len   = len;
        #2;
        chk("req_ready_idle", req_ready, 1'b1);
        cyc();
        req_valid = 1'b0;
        $display("request: write=%0d addr=%08h len=%0d", wr, addr, len);
    endtask

    task automatic ar_phase(input logic [31:0] addr, input logic [3:0] len, input int delay);
        for (int k = 0; k <= delay; k++) begin
            ARREADY_M = (k == delay);
            #2;
            chk("arvalid", ARVALID_M, 1'b1);
            chk("araddr", ARADDR_M, addr);
            chk("arlen", ARLEN_M, {4'h0, len});
            chk("arsize", ARSIZE_M, 3'b010);
            chk("arburst", ARBURST_M, 2'b01);
            chk("arid", ARID_M, 4'h0);
            chk("req_ready_busy", req_ready, 1'b0);
            cyc();
        end
        ARREADY_M = 1'b0;
    endtask

    // Slave offers n beats starting at data base; RLAST on index last_at.
    // rd_ready follows pat[cycle % plen].
    task automatic r_phase(input int n, input int last_at, input logic [3:0] pat,
                           input int plen, input logic [31:0] base);
        int i = 0;
        int pushed = 0;
        int cn = 0;
        logic [40:0] e;
        while (i < n && cn < 64) begin
            RVALID_M = 1'b1;
            RDATA_M  = base + 32'(i);
            RLAST_M  = (i == last_at);
            RID_M    = 4'h0;
            RRESP_M  = 2'b00;
            if (pushed == i) begin
                sb.push_back({4'h0, RLAST_M, 4'h0, RDATA_M});
                pushed++;
            end
            rd_ready = pat[cn % plen];
            #2;
            chk("rready_mirror", RREADY_M, rd_ready);
            if (rd_valid && rd_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    chk("rd_data", rd_data, e[31:0]);
                    chk("rd_last", rd_last, e[36]);
                    $display("read beat: data=%08h last=%0d", rd_data, rd_last);
                end
                i++;
            end
            cyc();
            cn++;
        end
        chk("read_beats_done", 64'(i), 64'(n));
        RVALID_M = 1'b0;
        RLAST_M  = 1'b0;
        rd_ready = 1'b0;
    endtask

    task automatic aw_phase(input logic [31:0] addr, input logic [3:0] len, input int delay);
        for (int k = 0; k <= delay; k++) begin
            AWREADY_M = (k == delay);
            wr_valid  = 1'b1;
            WREADY_M  = 1'b1;
            #2;
            chk("awvalid", AWVALID_M, 1'b1);
            chk("awaddr", AWADDR_M, addr);
            chk("awlen", AWLEN_M, {4'h0, len});
            chk("awsize", AWSIZE_M, 3'b010);
            chk("awburst", AWBURST_M, 2'b01);
            chk("awid", AWID_M, 4'h0);
            chk("no_w_before_aw", WVALID_M, 1'b0);
            cyc();
        end
        AWREADY_M = 1'b0;
    endtask

    // Client supplies beats 0..nb-1 of a burst of len+1 beats.
    task automatic w_phase(input int len, input int nb);
        logic [40:0] e;
        for (int i = 0; i < nb; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h11 * 32'(i + 1);
            wr_strb  = (i == len) ? 4'h3 : 4'hF;
            WREADY_M = 1'b1;
            sb.push_back({4'h0, (i == len), wr_strb, wr_data});
            #2;
            chk("wvalid", WVALID_M, 1'b1);
            chk("wr_ready", wr_ready, 1'b1);
            e = sb.pop_front();
            chk("wdata", WDATA_M, e[31:0]);
            chk("wstrb", WSTRB_M, e[35:32]);
            chk("wlast", WLAST_M, e[36]);
            $display("write beat: data=%08h strb=%h last=%0d", WDATA_M, WSTRB_M, WLAST_M);
            cyc();
        end
        wr_valid = 1'b0;
        WREADY_M = 1'b0;
    endtask

    task automatic b_phase(input logic [1:0] bresp, input logic [3:0] bid);
        BVALID_M = 1'b0;
        #2;
        chk("bready", BREADY_M, 1'b1);
        chk("no_done_in_b", done, 1'b0);
        cyc();
        BVALID_M = 1'b1;
        BRESP_M  = bresp;
        BID_M    = bid;
        #2;
        chk("bready_hs", BREADY_M, 1'b1);
        cyc();
        BVALID_M = 1'b0;
        BRESP_M  = 2'b00;
        BID_M    = 4'h0;
    endtask

    task automatic finish_chk(input logic [1:0] exp_resp);
        #2;
        chk("done_pulse", done, 1'b1);
        chk("resp", resp, exp_resp);
        chk("req_ready_during_done", req_ready, 1'b0);
        $display("done: resp=%0b", resp);
        cyc();
        #2;
        chk("done_cleared", done, 1'b0);
        chk("req_ready_after", req_ready, 1'b1);
    endtask

    initial begin
        ARESET    = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wr_data   = '0;   wr_strb   = '0;   wr_valid = 1'b0;
        rd_ready  = 1'b0;
        ARREADY_M = 1'b0; AWREADY_M = 1'b0; WREADY_M = 1'b0;
        RID_M = '0; RDATA_M = '0; RRESP_M = 2'b00; RLAST_M = 1'b0; RVALID_M = 1'b0;
        BID_M = '0; BRESP_M = 2'b00; BVALID_M = 1'b0;

        repeat (3) cyc();
        ARESET = 1'b0;
        #2;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_arvalid", ARVALID_M, 1'b0);
        chk("rst_awvalid", AWVALID_M, 1'b0);
        chk("rst_wvalid", WVALID_M, 1'b0);
        chk("rst_bready", BREADY_M, 1'b0);
        chk("rst_rready", RREADY_M, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_resp", resp, 2'b00);
        cyc();

        // 4-beat read, ARREADY after two wait cycles
        issue_req(1'b0, 32'h0000_1000, 4'd3);
        ar_phase(32'h0000_1000, 4'd3, 2);
        r_phase(4, 3, 4'hF, 1, 32'hA0);
        finish_chk(2'b00);

        // 2-beat write
        issue_req(1'b1, 32'h0000_0040, 4'd1);
        aw_phase(32'h0000_0040, 4'd1, 1);
        w_phase(1, 2);
        b_phase(2'b00, 4'h0);
        finish_chk(2'b00);

        // 2-beat read with rd_ready 1,0,0,1
        issue_req(1'b0, 32'h0000_2000, 4'd1);
        ar_phase(32'h0000_2000, 4'd1, 0);
        r_phase(2, 1, 4'b1001, 4, 32'hB0);
        finish_chk(2'b00);

        // single-beat write answered with SLVERR
        issue_req(1'b1, 32'h0000_0080, 4'd0);
        aw_phase(32'h0000_0080, 4'd0, 0);
        w_phase(0, 1);
        b_phase(2'b10, 4'h0);
        finish_chk(2'b10);

        // single-beat write answered with a foreign BID
        issue_req(1'b1, 32'h0000_00C0, 4'd0);
        aw_phase(32'h0000_00C0, 4'd0, 0);
        w_phase(0, 1);
        b_phase(2'b00, 4'h3);
        finish_chk(2'b10);

        // len=3 read terminated early by RLAST on beat 1
        issue_req(1'b0, 32'h0000_3000, 4'd3);
        ar_phase(32'h0000_3000, 4'd3, 0);
        r_phase(2, 1, 4'hF, 1, 32'hC0);
        finish_chk(2'b10);

        // reset while in the write-data phase after beat 0
        issue_req(1'b1, 32'h0000_0100, 4'd3);
        aw_phase(32'h0000_0100, 4'd3, 0);
        w_phase(3, 1);
        ARESET   = 1'b1;
        wr_valid = 1'b1;
        WREADY_M = 1'b1;
        cyc();
        #2;
        chk("rst_mid_wvalid", WVALID_M, 1'b0);
        chk("rst_mid_req_ready", req_ready, 1'b1);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_resp", resp, 2'b00);
        $display("reset during write burst applied");
        ARESET   = 1'b0;
        wr_valid = 1'b0;
        WREADY_M = 1'b0;
        sb.delete();
        cyc();

        // single-beat read after the aborted write
        issue_req(1'b0, 32'h0000_4000, 4'd0);
        ar_phase(32'h0000_4000, 4'd0, 0);
        r_phase(1, 0, 4'hF, 1, 32'hD0);
        finish_chk(2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
